// File: rtl/stage_5_output_buffer.sv
// Stage 5 of the entropy encoder: circular byte FIFO that absorbs 0..5 bytes per cycle
// from Stage 4 and emits one byte per cycle on a valid/ready stream with a frame-last tag.
module stage_5_output_buffer #(
  parameter int S5_BITSTREAM_WIDTH = 8,
  parameter int S5_ADDR_WIDTH      = 4,
  parameter int S5_FIFO_DEPTH      = 16
) (
  input  logic                          s5_clk,
  input  logic                          s5_reset,
  input  logic                          s5_flag_first,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [S5_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                    in_flag,
  input  logic                          in_flag_last,
  output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_done,
  output logic [1:0]                    out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [S5_BITSTREAM_WIDTH-1:0] mem [S5_FIFO_DEPTH];
  logic [S5_FIFO_DEPTH-1:0]      tag;
  logic [S5_BITSTREAM_WIDTH-1:0] in_bytes [5];

  logic [S5_ADDR_WIDTH-1:0] wr_ptr;
  logic [S5_ADDR_WIDTH-1:0] rd_ptr;
  logic [S5_ADDR_WIDTH:0]   occ;
  logic [S5_ADDR_WIDTH+1:0] occ_sum;

  logic       accept;
  logic       accept_first;
  logic       flag_illegal;
  logic       overflow;
  logic       pop;
  logic       tag_back;
  logic [2:0] n_req;
  logic [2:0] n_wr;

  assign in_bytes[0] = in_bit_1;
  assign in_bytes[1] = in_bit_2;
  assign in_bytes[2] = in_bit_3;
  assign in_bytes[3] = in_bit_4;
  assign in_bytes[4] = in_bit_5;

  // Write-side control; overflow is judged on occupancy before this cycle's pop.
  always_comb begin
    accept_first = (state == IDLE) && s5_flag_first;
    accept       = accept_first || (state == RUN);
    flag_illegal = (in_flag > 3'd5);
    n_req        = flag_illegal ? 3'd0 : in_flag;
    occ_sum      = {1'b0, occ} + {{(S5_ADDR_WIDTH-1){1'b0}}, n_req};
    overflow     = accept && (occ_sum > (S5_ADDR_WIDTH+2)'(S5_FIFO_DEPTH));
    n_wr         = (accept && !overflow) ? n_req : 3'd0;
    tag_back     = accept && in_flag_last && (n_wr == 3'd0) && (occ != '0);
  end

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_byte  = mem[rd_ptr];
  assign out_last  = out_valid && tag[rd_ptr];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    out_done   = 1'b0;
    case (state)
      IDLE:    if (s5_flag_first) state_next = in_flag_last ? DRAIN : RUN;
      RUN:     if (in_flag_last) state_next = DRAIN;
      DRAIN:   if (occ == '0) state_next = DONE;
      DONE: begin
        out_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s5_clk) begin
    if (s5_reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      out_err <= 2'b00;
      tag     <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr + S5_ADDR_WIDTH'(n_wr);
      occ    <= occ + (S5_ADDR_WIDTH+1)'(n_wr) - (S5_ADDR_WIDTH+1)'(pop);
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        tag[rd_ptr] <= 1'b0;
      end
      if (accept_first) out_err <= {flag_illegal, overflow};
      else              out_err <= out_err | {accept && flag_illegal, overflow};
      for (int i = 0; i < 5; i++) begin
        if (3'(i) < n_wr)
          tag[wr_ptr + S5_ADDR_WIDTH'(i)] <= in_flag_last && (3'(i) == n_wr - 3'd1);
      end
      // A zero-byte last group tags the newest stored byte; this write wins over a same-slot pop clear.
      if (tag_back) tag[wr_ptr - 1'b1] <= 1'b1;
    end
  end

  // NOTE: the byte array has no reset; out_valid is derived from occ, so stale contents are never visible.
  always_ff @(posedge s5_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (3'(i) < n_wr) mem[wr_ptr + S5_ADDR_WIDTH'(i)] <= in_bytes[i];
    end
  end

endmodule

// File: tb/tb_stage_5_output_buffer.sv
// Self-checking bench for stage_5_output_buffer: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_stage_5_output_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       first;
  logic [7:0] b1, b2, b3, b4, b5;
  logic [2:0] flag;
  logic       last;
  logic       ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_last;
  logic       out_done;
  logic [1:0] out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage_5_output_buffer dut (
    .s5_clk        (clk),
    .s5_reset      (rst),
    .s5_flag_first (first),
    .in_bit_1      (b1),
    .in_bit_2      (b2),
    .in_bit_3      (b3),
    .in_bit_4      (b4),
    .in_bit_5      (b5),
    .in_flag       (flag),
    .in_flag_last  (last),
    .out_byte      (out_byte),
    .out_valid     (out_valid),
    .out_ready     (ready),
    .out_last      (out_last),
    .out_done      (out_done),
    .out_err       (out_err)
  );

  // Reference model: a queue of stored bytes plus the frame phase flags.
  typedef struct {
    logic [7:0] b;
    logic       last;
  } ent_t;

  ent_t       q[$];
  bit         m_run, m_drain, m_done;
  logic [1:0] m_err;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run   = 0;
    m_drain = 0;
    m_done  = 0;
    m_err   = 2'b00;
  endtask

  task automatic compare_outputs();
    check("valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("byte", 32'(out_byte), 32'(q[0].b));
      check("last", 32'(out_last), 32'(q[0].last));
    end
    check("done", 32'(out_done), 32'(m_done));
    check("err", 32'(out_err), 32'(m_err));
  endtask

  // Applies one clock edge of the specification's rules to the model, using the driven inputs.
  task automatic model_step();
    logic [7:0] bv[5];
    bit   was_empty, idle, acc, do_pop, nxt_run, nxt_drain, nxt_done;
    int   n;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    bv[0] = b1; bv[1] = b2; bv[2] = b3; bv[3] = b4; bv[4] = b5;
    was_empty = (q.size() == 0);
    idle      = !m_run && !m_drain && !m_done;
    acc       = (idle && first) || m_run;
    do_pop    = !was_empty && ready;
    nxt_done  = m_drain && was_empty;
    nxt_drain = (m_drain && !was_empty) || (acc && last);
    nxt_run   = acc && !last;
    if (acc) begin
      if (idle) m_err = 2'b00;
      n = int'(flag);
      if (flag > 3'd5) begin
        m_err[1] = 1'b1;
        n = 0;
      end
      if (q.size() + n > 16) begin
        m_err[0] = 1'b1;
        n = 0;
      end
      for (int i = 0; i < n; i++) begin
        e.b    = bv[i];
        e.last = 1'b0;
        q.push_back(e);
      end
      if (last && q.size() > 0) begin
        e = q[q.size()-1];
        e.last = 1'b1;
        q[q.size()-1] = e;
      end
    end
    if (do_pop) void'(q.pop_front());
    m_run   = nxt_run;
    m_drain = nxt_drain;
    m_done  = nxt_done;
  endtask

  task automatic cyc(input logic r, input logic f, input logic [2:0] fl, input logic l, input logic rd,
                     input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                     input logic [7:0] a3, input logic [7:0] a4);
    rst = r; first = f; flag = fl; last = l; ready = rd;
    b1 = a0; b2 = a1; b3 = a2; b4 = a3; b5 = a4;
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input logic rd);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, rd, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic rand_group(input logic f, input logic [2:0] fl, input logic l, input logic rd);
    cyc(1'b0, f, fl, l, rd, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int rate;
    logic [2:0] fl;
    rst = 1'b1; first = 1'b0; flag = 3'd0; last = 1'b0; ready = 1'b0;
    b1 = '0; b2 = '0; b3 = '0; b4 = '0; b5 = '0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: three-byte first group, streamed out back to back
    cyc(1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00);
    check("t1_b0", 32'(out_byte), 32'hA1);
    idle_cyc(1'b1);
    check("t1_b1", 32'(out_byte), 32'hB2);
    idle_cyc(1'b1);
    check("t1_b2", 32'(out_byte), 32'hC3);
    idle_cyc(1'b1);
    check("t1_empty", 32'(out_valid), 32'h0);

    // 2: four five-byte groups with the consumer stalled; the fourth overflows
    for (int g = 0; g < 4; g++) rand_group(1'b0, 3'd5, 1'b0, 1'b0);
    check("t2_err", 32'(out_err), 32'h1);
    for (int k = 0; k < 16; k++) idle_cyc(1'b1);
    check("t2_drained", 32'(out_valid), 32'h0);

    // 3: last group of two bytes, then drain and done
    cyc(1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00);
    check("t3_b0_last", 32'(out_last), 32'h0);
    idle_cyc(1'b1);
    check("t3_b1", 32'(out_byte), 32'h20);
    check("t3_b1_last", 32'(out_last), 32'h1);
    idle_cyc(1'b1);
    check("t3_done_early", 32'(out_done), 32'h0);
    idle_cyc(1'b1);
    check("t3_done", 32'(out_done), 32'h1);
    idle_cyc(1'b1);

    // 4: zero-byte last group tags the third stored byte
    rand_group(1'b1, 3'd3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    check("t4_third_last", 32'(out_last), 32'h1);
    for (int k = 0; k < 4; k++) idle_cyc(1'b1);

    // 5: zero-byte last group with an empty buffer
    cyc(1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("t5_novalid", 32'(out_valid), 32'h0);
    idle_cyc(1'b1);
    check("t5_done", 32'(out_done), 32'h1);
    idle_cyc(1'b1);

    // 6: illegal count, then reset during DRAIN
    cyc(1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("t6_err", 32'(out_err), 32'h2);
    rand_group(1'b0, 3'd4, 1'b1, 1'b0);
    idle_cyc(1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    rand_group(1'b0, 3'd5, 1'b0, 1'b1);
    rand_group(1'b0, 3'd3, 1'b1, 1'b1);
    check("t6_ignored", 32'(out_valid), 32'h0);

    // Random traffic with varying consumer throughput
    rate = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) rate = int'($urandom_range(0, 100));
      fl = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 5) == 0), fl,
          1'($urandom_range(0, 9) == 0), 1'(int'($urandom_range(0, 99)) < rate),
          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
